// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver.
// Arms the receiver through rx_valid and detects each completed byte on a
// rising edge of rx_ready. Each byte is buffered in a DEPTH-entry FIFO and
// presented to the consumer with a show-ahead valid/ready handshake.
// Optional feature: define UART_RX_TIMEOUT_EN to enable the idle-line
// end-of-message pulse on 'timeout'. Without it, timeout is tied low.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 52080,
  parameter int unsigned TO_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              timeout
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_LISTEN = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rx_valid;
  logic               r_rdy_q;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_level;
  logic               r_m_valid;
  logic [7:0]         r_m_data;
  logic               r_overflow;
  logic [7:0]         r_mem [DEPTH];

  logic               w_strobe;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_fills;
  logic [CNT_W-1:0]   w_wr_cnt_nxt;
  logic [CNT_W-1:0]   w_rd_cnt_nxt;
  logic [CNT_W-1:0]   w_level_nxt;
  logic [ADDR_W-1:0]  w_wr_ptr;
  logic [ADDR_W-1:0]  w_rd_ptr_nxt;

  // Byte strobe, FIFO push/pop decisions and next-cycle bookkeeping.
  always_comb begin
    w_strobe     = rx_ready & ~r_rdy_q;
    w_full       = (r_level == CNT_W'(DEPTH));
    w_pop        = r_m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_push       = w_strobe & (~w_full | w_pop);
    w_ovf_set    = w_strobe & w_full & ~w_pop;
    w_fills      = w_push & ~w_pop & (r_level == CNT_W'(DEPTH - 1));
    w_wr_cnt_nxt = r_wr_cnt + CNT_W'(w_push);
    w_rd_cnt_nxt = r_rd_cnt + CNT_W'(w_pop);
    w_level_nxt  = w_wr_cnt_nxt - w_rd_cnt_nxt;
    w_wr_ptr     = r_wr_cnt[ADDR_W-1:0];
    w_rd_ptr_nxt = w_rd_cnt_nxt[ADDR_W-1:0];
  end

  // Receiver arming FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF: begin
        if (enable) begin
          w_state_nxt = w_full ? ST_HOLD : ST_LISTEN;
        end
      end
      ST_LISTEN: begin
        if (!enable) begin
          w_state_nxt = ST_OFF;
        end else if (w_full || w_fills) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          w_state_nxt = ST_OFF;
        end else if (!w_full) begin
          w_state_nxt = ST_LISTEN;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // FSM state register; rx_valid is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_valid <= (w_state_nxt == ST_LISTEN);
    end
  end

  // Edge detector, FIFO counters, registered handshake outputs, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_q    <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_level    <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_q   <= rx_ready;
      r_wr_cnt  <= w_wr_cnt_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_level   <= w_level_nxt;
      r_m_valid <= (w_level_nxt != '0);
      // Show-ahead head; forward the incoming byte when it lands in the head slot.
      if (w_push && (w_wr_ptr == w_rd_ptr_nxt)) begin
        r_m_data <= rx_data;
      end else begin
        r_m_data <= r_mem[w_rd_ptr_nxt];
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because the counters gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= rx_data;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_arm;
  logic            r_timeout;

  // Idle-line counter: armed by each accepted push, fires once, frozen while OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_to_arm  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_push) begin
        r_to_cnt <= '0;
        r_to_arm <= 1'b1;
      end else if (r_to_arm && (r_state != ST_OFF)) begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          r_timeout <= 1'b1;
          r_to_arm  <= 1'b0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign timeout = r_timeout;
`else
  // Timeout parameters are only meaningful when the feature is built in.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYC[0], TO_W[0]};
  assign timeout      = 1'b0;
`endif

  assign rx_valid = r_rx_valid;
  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic            clk;
  logic            rst;
  logic            enable;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            ovf_clr;
  logic            timeout;

  uart_rx_ctrl #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (16),
    .TO_W        (20)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: byte queue, sticky overflow, previous rx_ready.
  logic [7:0] mq[$];
  logic [7:0] got_q[$];
  logic       mdl_ovf = 1'b0;
  logic       mdl_rdy_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: record consumed bytes, advance the model, compare after the edge.
  task automatic tick();
    int  sz_before;
    logic strobe;
    if (!rst && m_valid && m_ready) got_q.push_back(m_data);
    @(posedge clk);
    sz_before = mq.size();
    if (rst) begin
      mq.delete();
      mdl_ovf   = 1'b0;
      mdl_rdy_q = 1'b0;
    end else begin
      strobe    = rx_ready && !mdl_rdy_q;
      mdl_rdy_q = rx_ready;
      if (mq.size() != 0 && m_ready) void'(mq.pop_front());
      if (strobe && mq.size() < DEPTH) mq.push_back(rx_data);
      if (strobe && mq.size() == DEPTH && sz_before == DEPTH && !m_ready) mdl_ovf = 1'b1;
      else if (ovf_clr) mdl_ovf = 1'b0;
    end
    #1;
    if (!rst) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
      chk("overflow", 32'(overflow), 32'(mdl_ovf));
      if (mq.size() == sz_before)
        chk("rx_valid", 32'(rx_valid), 32'(enable && (mq.size() < DEPTH)));
`ifndef UART_RX_TIMEOUT_EN
      chk("timeout_tied", 32'(timeout), 32'd0);
`endif
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    tick();
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic drain(input int cycles);
    m_ready = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    m_ready = 1'b0;
  endtask

  int mr_pct;

  initial begin
    enable   = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    rst      = 1'b0;

    // Reset with enable high, receiver armed shortly after release.
    do_reset();
    tick();
    tick();
    chk("arm_after_reset", 32'(rx_valid), 32'd1);

    // Two bytes through an always-ready consumer.
    m_ready = 1'b1;
    send(8'hA5);
    send(8'h3C);
    tick();
    tick();
    chk("pass_cnt", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("pass_b0", 32'(got_q[0]), 32'hA5);
      chk("pass_b1", 32'(got_q[1]), 32'h3C);
    end
    chk("pass_level", 32'(level), 32'd0);

    // Fill, hold, overflow, drain, clear.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i));
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_hold", 32'(rx_valid), 32'd0);
    send(8'hFF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    drain(10);
    chk("ovf_drain_cnt", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) chk("ovf_drain_byte", 32'(got_q[i]), 32'(i));
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    tick();
    drain(10);
    chk("pp_cnt", 32'(got_q.size()), 32'd9);
    if (got_q.size() == 9) begin
      chk("pp_first", 32'(got_q[0]), 32'h10);
      chk("pp_last", 32'(got_q[8]), 32'h55);
    end

    // Level held high counts once; asynchronous reset mid-stream.
    do_reset();
    m_ready  = 1'b0;
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("held_level", 32'(level), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    do_reset();

`ifdef UART_RX_TIMEOUT_EN
    // Single idle pulse exactly 16 cycles after the push, none afterwards.
    do_reset();
    m_ready  = 1'b0;
    rx_data  = 8'h42;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("to_at_push", 32'(timeout), 32'd0);
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk("to_pulse", 32'(timeout), 32'(k == 16));
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    mr_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) mr_pct = $urandom_range(0, 100);
      enable   = ($urandom_range(0, 99) < 92);
      rx_ready = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      m_ready  = ($urandom_range(0, 99) < mr_pct);
      ovf_clr  = ($urandom_range(0, 49) == 0);
      tick();
    end
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;
    drain(12);
    chk("final_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
